// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pulls bytes from an upstream show-ahead FIFO.
// Frames are sent back-to-back with no idle gap while the FIFO stays non-empty.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       empty,
  input  logic [7:0] rd_data,
  output logic       read,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             bit_done;

  assign bit_done = (baud_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      read      <= 1'b0;
      busy      <= 1'b0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      read <= 1'b0;
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (!empty) begin
            read      <= 1'b1;
            shift_reg <= rd_data;
            state     <= START;
            tx        <= 1'b0;
            busy      <= 1'b1;
          end
        end

        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end

        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP;
              tx      <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_reg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end

        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            // Chain straight into the next start bit so there is no idle gap
            if (!empty) begin
              read      <= 1'b1;
              shift_reg <= rd_data;
              state     <= START;
              tx        <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 The block SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 The block SHALL have port empty  input  1  upstream FIFO empty flag; low means rd_data holds a valid head byte.
REQ-005 The block SHALL have port rd_data  input  8  upstream FIFO head byte, valid whenever empty is low.
REQ-006 The block SHALL have port read  output  1  single-cycle pop strobe to upstream FIFO; head removed at the edge where read is high.
REQ-007 The block SHALL have port tx  output  1  UART serial line, idle high.
REQ-008 The block SHALL have port busy  output  1  high while a frame is being transmitted (START, DATA, STOP states).

Function
REQ-009 The block SHALL transmit 8N1 frames: one start bit (0), 8 data bits LSB first, one stop bit (1); no parity.
REQ-010 Each bit SHALL be held on tx for exactly CLKS_PER_BIT cycles; one frame SHALL occupy exactly 10*CLKS_PER_BIT cycles.
REQ-011 The block SHALL implement states IDLE, START, DATA, STOP; tx, read, busy SHALL be registered outputs.
REQ-012 IDLE: tx=1, busy=0; on a cycle where empty=0 the block SHALL drive read=1 for that one cycle, latch rd_data into an 8-bit shift register at the same edge, and enter START.
REQ-013 START: tx=0 for CLKS_PER_BIT cycles, then enter DATA with bit index 0.
REQ-014 DATA: tx = shift register bit [index]; after CLKS_PER_BIT cycles index increments; after index 7 completes, enter STOP.
REQ-015 STOP: tx=1 for CLKS_PER_BIT cycles.
REQ-016 Back-to-back: on the final STOP cycle, if empty=0, the block SHALL pulse read, latch rd_data, and enter START directly, giving zero idle gap between frames; if empty=1, it SHALL enter IDLE.
REQ-017 read SHALL never be asserted while empty=1, never for more than one consecutive cycle, and never more than once per frame.
REQ-018 Changes on rd_data or empty during START/DATA/STOP SHALL NOT affect the frame in progress.
REQ-019 The baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, count 0..CLKS_PER_BIT-1, and clear on every bit boundary and on state entry.
REQ-020 The bit index SHALL be 3 bits and SHALL NOT wrap mid-frame.

Reset
REQ-021 While reset=1 at a rising edge: state=IDLE, tx=1, read=0, busy=0, baud counter=0, bit index=0, shift register=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame: tx=1 from the following edge, the popped byte is discarded, and no further read occurs until reset deasserts.
REQ-023 The first possible read after reset deasserts SHALL be in the first cycle with reset=0 and empty=0.

Verification (CLKS_PER_BIT=4)
REQ-024 Reset held 2 cycles, empty=1 -> tx=1, read=0, busy=0 throughout and for 50 cycles after release.
REQ-025 Single byte: empty=0, rd_data=8'hA5 one cycle then empty=1 -> exactly one read pulse; tx sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1; busy high 40 cycles; then IDLE.
REQ-026 Back-to-back: FIFO holds 8'h00, 8'hFF -> two read pulses exactly 40 cycles apart; tx: 0, eight 0s, 1, 0, eight 1s, 1 with no idle cycle between frames.
REQ-027 Data change mid-frame: rd_data switches 8'h3C to 8'hC3 during DATA -> frame still serializes 8'h3C (0,0,1,1,1,1,0,0 LSB first).
REQ-028 Reset at cycle 15 of a frame -> tx=1 at next edge, busy=0, read=0; after release with empty=0, a new full frame starts with a fresh read.
REQ-029 Long run: 16 queued bytes i*(i+10) mod 256, i=0..15 -> 16 read pulses, decoded bytes match in order, no read while empty=1.
